// File: rtl/lifo_stack_pkg.sv
// Shared sizing defaults and the occupancy-pointer width helper for lifo_stack.
package lifo_stack_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 3;

    // Pointer counts 0..DEPTH inclusive, so it needs one more code than DEPTH.
    function automatic int ptr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Push/pop strobes, data and status flags between a stack user (master) and lifo_stack (slave).
// err exists only when LIFO_STACK_ERR_EN is defined.
interface lifo_stack_if #(parameter int WIDTH = 8);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
`ifdef LIFO_STACK_ERR_EN
    logic             err;
`endif

    modport master (
        output push, pop, data_in,
        input  data_out, full, empty
`ifdef LIFO_STACK_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, full, empty
`ifdef LIFO_STACK_ERR_EN
        , output err
`endif
    );

endinterface

// File: rtl/lifo_stack_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one combinational read port.
// Out-of-range indices write nothing and read as zero.
module lifo_stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int IW    = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_idx) < DEPTH)) begin
            regs[wr_idx] <= wr_data;
        end
    end

    assign rd_data = (int'(rd_idx) < DEPTH) ? regs[rd_idx] : '0;

endmodule

// File: rtl/lifo_stack.sv
// DEPTH-entry LIFO with registered pop data (1 edge) and flags from the registered pointer.
// No backpressure: push-when-full / pop-when-empty are dropped; LIFO_STACK_ERR_EN adds a sticky err flag.
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    lifo_stack_if.slave bus
);

    localparam int PW = ptr_width(DEPTH);

    logic [PW-1:0]    pointer;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    wr_idx;
    logic [WIDTH-1:0] top_word;
    logic [WIDTH-1:0] data_out_q;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;
    logic             pop_taken;
    logic             wr_en;

    assign full    = (pointer == PW'(DEPTH));
    assign empty   = (pointer == '0);
    assign top_idx = pointer - PW'(1);

    always_comb begin
        do_replace = bus.push && bus.pop && !empty;
        // push+pop on an empty stack degrades to a plain push
        do_push    = bus.push && !full && (!bus.pop || empty);
        do_pop     = bus.pop && !bus.push && !empty;
        pop_taken  = bus.pop && !empty;
        wr_en      = rst && (do_push || do_replace);
        wr_idx     = do_replace ? top_idx : pointer;
    end

    lifo_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IW    (PW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (bus.data_in),
        .rd_idx  (top_idx),
        .rd_data (top_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pointer    <= '0;
            data_out_q <= '0;
        end else begin
            if (do_push) begin
                pointer <= pointer + PW'(1);
            end else if (do_pop) begin
                pointer <= pointer - PW'(1);
            end
            if (pop_taken) begin
                data_out_q <= top_word;
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.full     = full;
    assign bus.empty    = empty;

`ifdef LIFO_STACK_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if ((bus.push && !bus.pop && full) || (bus.pop && empty)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboarded bench: a queue-based stack model predicts each edge; a negedge monitor compares.
module tb_lifo_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    typedef struct {
        logic [WIDTH-1:0] dout;
        logic             full;
        logic             empty;
        logic             err;
    } exp_t;

    logic clk;
    logic rst;

    lifo_stack_if #(.WIDTH(WIDTH)) bus ();

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t             exp_q [$];
    logic [WIDTH-1:0] stk [$];
    logic [WIDTH-1:0] m_dout;
    logic             m_err;
    int               n_checks;
    int               n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference behaviour: a plain queue whose back is the top of stack.
    task automatic step(input logic r, input logic pu, input logic po, input logic [WIDTH-1:0] d);
        exp_t e;
        int   sz;
        rst         = r;
        bus.push    = pu;
        bus.pop     = po;
        bus.data_in = d;
        sz = stk.size();
        if (!r) begin
            stk.delete();
            m_dout = '0;
            m_err  = 1'b0;
        end else begin
            if ((pu && !po && sz == DEPTH) || (po && sz == 0)) m_err = 1'b1;
            if (pu && po && sz > 0) begin
                m_dout = stk[sz-1];
                stk[sz-1] = d;
            end else if (pu && sz < DEPTH) begin
                stk.push_back(d);
            end else if (po && !pu && sz > 0) begin
                m_dout = stk.pop_back();
            end
        end
        e.dout  = m_dout;
        e.full  = (stk.size() == DEPTH);
        e.empty = (stk.size() == 0);
        e.err   = m_err;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("data_out", 32'(bus.data_out), 32'(e.dout));
            chk("full", 32'(bus.full), 32'(e.full));
            chk("empty", 32'(bus.empty), 32'(e.empty));
`ifdef LIFO_STACK_ERR_EN
            chk("err", 32'(bus.err), 32'(e.err));
`endif
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_dout   = '0;
        m_err    = 1'b0;
        rst      = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.data_in = '0;

        // reset, idle, fill, overfill, drain, underflow
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        step(1'b1, 1'b1, 1'b0, 8'hBB);
        step(1'b1, 1'b1, 1'b0, 8'hCC);
        step(1'b1, 1'b1, 1'b0, 8'hDD);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // replace-top
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        step(1'b1, 1'b1, 1'b0, 8'hBB);
        step(1'b1, 1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b0, 1'b1, 8'h00);

        // reset overrides a push in the same cycle
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        step(1'b1, 1'b1, 1'b0, 8'hBB);
        step(1'b0, 1'b1, 1'b0, 8'hEE);
        step(1'b1, 1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom));
        end

        bus.push = 1'b0;
        bus.pop  = 1'b0;
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d pending expectations, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
